// File: rtl/lsu_dmem_slave.sv
// Data-memory responder: byte/half/word stores with lane masking, sign/zero-extended loads.
// Response pulses LATENCY cycles after accept; req_ready is low from accept until the response has retired.
module lsu_dmem_slave #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic                  w_accept;
  logic                  w_in_resp;
  logic [31:0]           w_off;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_f3_ok;
  logic                  w_mis;
  logic                  w_err;
  logic                  w_commit;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_lane;
  logic [31:0]           w_load;

  logic [31:0] r_mem [2**DEPTH_LOG2];

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_funct3 <= 3'd0;
    end else if (w_accept) begin
      r_wen    <= req_wen;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_cnt_next   = LAT_M1;
          w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A reset landing on the response cycle suppresses both the pulse and the store.
  assign w_in_resp = (r_state == S_RESP) && !rst;

  assign w_off = r_addr - BASE_ADDR;
  assign w_oor = (w_off >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign w_idx = w_off[DEPTH_LOG2+1:2];

  always_comb begin
    w_f3_ok = 1'b0;
    if (r_wen) begin
      case (r_funct3)
        3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
        default:                w_f3_ok = 1'b0;
      endcase
    end else begin
      case (r_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
        default:                                w_f3_ok = 1'b0;
      endcase
    end
  end

  assign w_mis = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                 ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_err    = !w_f3_ok || w_mis || w_oor;
  assign w_commit = w_in_resp && r_wen && !w_err;

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = 4'b0011 << r_addr[1:0];
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_word = r_mem[w_idx];
  assign w_lane    = w_rd_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = 32'd0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load = w_rd_word;
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = 32'd0;
    endcase
  end

  assign resp_valid = w_in_resp;
  assign resp_err   = w_in_resp && w_err;
  assign resp_rdata = (w_in_resp && !r_wen && !w_err) ? w_load : 32'd0;

endmodule

// File: tb/tb_lsu_dmem_slave.sv
// Bench for lsu_dmem_slave: three instances (LATENCY 1/2/3) checked against a byte-addressed reference model.
module tb_lsu_dmem_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NWORDS = 1024;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  req_funct3 [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_b [int unsigned];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_dmem_slave #(
      .DEPTH_LOG2(10),
      .BASE_ADDR (BASE),
      .LATENCY   (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_funct3(req_funct3[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired (got hang, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as individual bytes, access rules from the RV32I load/store definitions.
  task automatic ref_access(input int inst, input bit wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            output logic [31:0] rd, output bit err);
    int          size;
    bit          legal;
    bit          sgn;
    logic [31:0] off;
    logic [31:0] val;
    int unsigned key;
    legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn   = !f3[2] && (size < 4);
    off   = addr - BASE;
    err   = !legal || ((addr % size) != 0) || ((off / 4) >= NWORDS);
    rd    = 32'd0;
    if (!err) begin
      if (wen) begin
        for (int b = 0; b < size; b++) begin
          key = (inst << 16) | (off + b);
          ref_b[key] = 8'((wdata >> (8 * b)) & 32'hFF);
        end
      end else begin
        val = 32'd0;
        for (int b = 0; b < size; b++) begin
          key = (inst << 16) | (off + b);
          if (ref_b.exists(key)) val = val | (32'(ref_b[key]) << (8 * b));
        end
        if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
        rd = val;
      end
    end
  endtask

  task automatic do_req(input int inst, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input string tag,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    @(negedge clk);
    req_valid[inst]  = 1'b1;
    req_wen[inst]    = wen;
    req_addr[inst]   = addr;
    req_wdata[inst]  = wdata;
    req_funct3[inst] = f3;
    for (int n = 0; n < 50 && !req_ready[inst]; n++) @(negedge clk);
    if (!req_ready[inst]) chk({tag, ":ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[inst]  = 1'b0;
    req_wen[inst]    = 1'($urandom);
    req_addr[inst]   = $urandom;
    req_wdata[inst]  = $urandom;
    req_funct3[inst] = 3'($urandom);
    ref_access(inst, wen, addr, wdata, f3, exp_rd, exp_err);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid[inst]) begin
        lat = n;
        break;
      end
      chk({tag, ":idle_rdata"}, resp_rdata[inst], 32'd0);
    end
    got_rd  = resp_rdata[inst];
    got_err = resp_err[inst];
    chk({tag, ":latency"}, 32'(lat), 32'(inst + 1));
    chk({tag, ":rdata"}, got_rd, exp_rd);
    chk({tag, ":err"}, {31'd0, got_err}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, ":pulse_width"}, {31'd0, resp_valid[inst]}, 32'd0);
  endtask

  task automatic stream(input int inst, input int ncyc);
    int lat;
    lat = inst + 1;
    @(negedge clk);
    req_valid[inst]  = 1'b1;
    req_wen[inst]    = 1'b0;
    req_addr[inst]   = BASE;
    req_wdata[inst]  = 32'd0;
    req_funct3[inst] = 3'b010;
    for (int i = 0; i < ncyc; i++) begin
      chk($sformatf("stream%0d:ready[%0d]", lat, i), {31'd0, req_ready[inst]},
          32'((i % (lat + 1)) == 0));
      chk($sformatf("stream%0d:resp[%0d]", lat, i), {31'd0, resp_valid[inst]},
          32'((i % (lat + 1)) == lat));
      @(negedge clk);
    end
    req_valid[inst] = 1'b0;
    repeat (lat + 3) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]        = 1'b1;
      req_valid[i]  = 1'b0;
      req_wen[i]    = 1'b0;
      req_addr[i]   = 32'd0;
      req_wdata[i]  = 32'd0;
      req_funct3[i] = 3'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d:ready", i), {31'd0, req_ready[i]}, 32'd1);
      chk($sformatf("reset%0d:valid", i), {31'd0, resp_valid[i]}, 32'd0);
      chk($sformatf("reset%0d:rdata", i), resp_rdata[i], 32'd0);
      chk($sformatf("reset%0d:err", i), {31'd0, resp_err[i]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    for (int w = 0; w < 17; w++) do_req(1, 1'b1, BASE + 32'(4 * w), 32'd0, 3'b010, "preload", rd, er);
    do_req(2, 1'b1, BASE + 32'h40, 32'd0, 3'b010, "preload2", rd, er);

    do_req(1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 3'b010, "sw_10", rd, er);
    do_req(1, 1'b0, BASE + 32'h10, 32'd0, 3'b010, "lw_10", rd, er);
    chk("lw_10:value", rd, 32'hDEAD_BEEF);

    do_req(1, 1'b1, BASE + 32'h20, 32'h1122_3344, 3'b010, "sw_20", rd, er);
    do_req(1, 1'b1, BASE + 32'h22, 32'h0000_00F0, 3'b000, "sb_22", rd, er);
    do_req(1, 1'b0, BASE + 32'h20, 32'd0, 3'b010, "lw_20", rd, er);
    chk("lw_20:value", rd, 32'h11F0_3344);
    do_req(1, 1'b0, BASE + 32'h22, 32'd0, 3'b000, "lb_22", rd, er);
    chk("lb_22:value", rd, 32'hFFFF_FFF0);
    do_req(1, 1'b0, BASE + 32'h22, 32'd0, 3'b100, "lbu_22", rd, er);
    chk("lbu_22:value", rd, 32'h0000_00F0);
    do_req(1, 1'b0, BASE + 32'h22, 32'd0, 3'b001, "lh_22", rd, er);
    chk("lh_22:value", rd, 32'h0000_11F0);

    do_req(1, 1'b0, BASE + 32'h2, 32'd0, 3'b010, "lw_mis", rd, er);
    chk("lw_mis:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b1, BASE + 32'h3, 32'h0000_FFFF, 3'b001, "sh_mis", rd, er);
    chk("sh_mis:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b0, BASE, 32'd0, 3'b010, "lw_0", rd, er);
    chk("lw_0:unchanged", rd, 32'd0);
    do_req(1, 1'b0, 32'h7FFF_FFFC, 32'd0, 3'b010, "lw_below", rd, er);
    chk("lw_below:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b0, 32'h8000_1000, 32'd0, 3'b010, "lw_above", rd, er);
    chk("lw_above:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b0, BASE, 32'd0, 3'b011, "ld_f3bad", rd, er);
    chk("ld_f3bad:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b1, BASE + 32'h4, 32'h1234_5678, 3'b100, "st_f3bad", rd, er);
    chk("st_f3bad:errflag", {31'd0, er}, 32'd1);
    do_req(1, 1'b0, BASE + 32'h4, 32'd0, 3'b010, "lw_4", rd, er);
    chk("lw_4:unchanged", rd, 32'd0);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h8000_1000 : 32'h7FFF_FFFC;
      do_req(1, 1'($urandom), a, $urandom, 3'($urandom_range(0, 7)),
             $sformatf("rand%0d", t), rd, er);
    end

    stream(0, 8);
    stream(2, 12);

    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_wen[2]    = 1'b1;
    req_addr[2]   = BASE + 32'h40;
    req_wdata[2]  = 32'hA5A5_A5A5;
    req_funct3[2] = 3'b010;
    chk("rstmid:ready_before", {31'd0, req_ready[2]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    chk("rstmid:no_pulse_in_rst", {31'd0, resp_valid[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    chk("rstmid:ready_after", {31'd0, req_ready[2]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rstmid:no_pulse[%0d]", i), {31'd0, resp_valid[2]}, 32'd0);
      @(negedge clk);
    end
    do_req(2, 1'b0, BASE + 32'h40, 32'd0, 3'b010, "rstmid_lw", rd, er);
    chk("rstmid_lw:prior", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_slave.md
Name: lsu_dmem_slave

Overview:
Data-memory responder on the far end of the core's load/store path. It accepts one request at a time: the byte address comes from the ALU result and store data from register rs2. Each request is qualified by the instruction's funct3. The block performs byte/half/word stores with lane masking, or returns sign/zero-extended load data after a fixed, parameterised latency. It holds the data RAM itself and models the multi-cycle memory the core will face once it leaves single-cycle operation.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request acceptance to response pulse; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_wen  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_funct3  input  3  RV32I funct3 of the load/store
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out of range, or illegal funct3

Behaviour:
- Reset: the FSM goes to IDLE and the latency counter clears to 0.
  - Output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - A handshake occurs when req_valid&&req_ready. On that edge the block latches wen, addr, wdata and funct3, and loads the counter with LATENCY-1.
  - The next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle. When the counter reaches 1, the next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle. The next state is IDLE.
  - req_ready=0 in RESP, so back-to-back requests are spaced LATENCY+1 cycles apart.
- Latency: resp_valid is high exactly LATENCY cycles after the accept edge.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets err.
- Alignment: err is set for a half-word access with addr[0]=1, or a word access with addr[1:0]!=0.
- Range: err is set if (addr-BASE_ADDR)>>2 >= 2^DEPTH_LOG2. The unsigned subtraction wraps, so addresses below BASE_ADDR are out of range.
- Store commit:
  - Happens on the RESP-cycle edge, and only if err=0.
  - Byte-enable mask is 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, and 1111 for SW.
  - Data is replicated across lanes before masking. Unmasked bytes are unchanged.
- Load read:
  - The RAM is read combinationally from the latched address while in RESP.
  - The lane is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - resp_rdata is 0 whenever resp_valid=0, and 0 on error.
- Error effects: on error, resp_err=1 with resp_valid. There is no RAM write, and the block returns to IDLE normally.
- Reset mid-operation: if rst is asserted in WAIT or RESP, the transaction is aborted. No store commits, no resp_valid pulse is produced, and the FSM returns to IDLE the next cycle.
- Input stability: req_* inputs are sampled only at acceptance, so changes to them during WAIT/RESP are ignored.

Test Plan:
- SW then LW, LATENCY=2:
  - Stimulus: SW addr 0x8000_0010, wdata 0xDEAD_BEEF; then LW at the same address.
  - Required: each resp_valid arrives 2 cycles after its accept. The LW returns 0xDEADBEEF with resp_err=0.
- Byte/half lanes:
  - Stimulus: start from word 0x8000_0020 = 0x1122_3344 (SW). Then SB 0x8000_0022 with wdata 0x0000_00F0, then LW 0x8000_0020.
  - Required: the LW returns 0x11F0_3344.
  - Then LB at 0x8000_0022 -> 0xFFFF_FFF0, LBU at 0x8000_0022 -> 0x0000_00F0, LH at 0x8000_0022 -> 0x0000_11F0.
- Misalignment and range:
  - LW at 0x8000_0002 -> resp_err=1, resp_rdata=0.
  - SH at 0x8000_0003 -> resp_err=1; a following LW at 0x8000_0000 shows the word unchanged.
  - LW at 0x7FFF_FFFC -> resp_err=1. LW at 0x8000_1000 with DEPTH_LOG2=10 -> resp_err=1.
- Illegal funct3: load with funct3=011 -> resp_err=1; store with funct3=100 -> resp_err=1, no write.
- Handshake spacing:
  - Stimulus: hold req_valid=1 continuously with LATENCY=1.
  - Required: req_ready toggles 1,0,1,0 and accepts occur every 2 cycles.
  - Rerun with LATENCY=3: accepts occur every 4 cycles, and responses never overlap.
- Reset mid-op:
  - Stimulus: SW 0x8000_0040 with 0xA5A5_A5A5, LATENCY=3. Assert rst for one cycle in the cycle after acceptance.
  - Required: no resp_valid pulse. A subsequent LW returns the prior contents (0 after a preload of 0), and req_ready=1 the cycle after rst deasserts.
